// File: rtl/gray_code_converter_pipe.sv
// Gray <-> binary converter with a single-entry ready/valid output register.
// Mode-0 (Gray) input words are checked for adjacency against the previous Gray word.
module gray_code_converter_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_err
);

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             mode_p1;
    logic             err_p1;
    logic [WIDTH-1:0] last_gray;
    logic             has_last;
    logic [CNT_W-1:0] err_cnt;

    logic             accept_p0;
    logic [WIDTH-1:0] conv_p0;
    logic             viol_p0;

    // Stage p0: combinational conversion and adjacency check of the incoming word
    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready;

    always_comb begin
        conv_p0 = in_mode ? bin_to_gray(in_data) : gray_to_bin(in_data);
        viol_p0 = accept_p0 && !in_mode && has_last
                  && (popcount(in_data ^ last_gray) > 32'd1);
    end

    // Stage p1: output register, Gray history and saturating violation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            mode_p1   <= 1'b0;
            err_p1    <= 1'b0;
            last_gray <= '0;
            has_last  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (accept_p0) begin
                vld_p1  <= 1'b1;
                data_p1 <= conv_p0;
                mode_p1 <= in_mode;
                err_p1  <= viol_p0;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end

            if (accept_p0 && !in_mode) begin
                last_gray <= in_data;
                has_last  <= 1'b1;
            end

            // A clear request takes priority over a same-cycle violation
            if (clr_err) begin
                err_cnt <= '0;
            end else if (viol_p0) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_mode  = mode_p1;
    assign out_err   = err_p1;
    assign err_count = err_cnt;

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Directed bench for gray_code_converter_pipe: conversion, backpressure, adjacency
// errors, counter saturation (second instance with CNT_W=2) and async reset.
module tb_gray_code_converter_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_mode;
    logic [3:0] in_data;
    logic       out_ready;
    logic       clr_err;

    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_mode;
    logic       out_err;
    logic [7:0] err_count;

    logic       in_ready2;
    logic       out_valid2;
    logic [3:0] out_data2;
    logic       out_mode2;
    logic       out_err2;
    logic [1:0] err_count2;

    int tests;
    int fails;

    gray_code_converter_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_err(out_err), .err_count(err_count), .clr_err(clr_err)
    );

    gray_code_converter_pipe #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_mode(out_mode2), .out_err(out_err2), .err_count(err_count2), .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word for one edge; on return the accepted word is on the outputs.
    task automatic send(input logic m, input logic [3:0] d);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = 4'b0000;
        out_ready = 1'b1;
        clr_err   = 1'b0;

        // Reset state, and accepts are ignored while reset is held
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(1'b0, 4'b1010);
        chk("rst_ignore_accept", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        #2;

        // Gray-to-binary stream, back-to-back
        send(1'b0, 4'b0000);
        chk("g2b_0000", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'b0000});
        send(1'b0, 4'b0001);
        chk("g2b_0001", {28'd0, out_data}, 32'h1);
        send(1'b0, 4'b0011);
        chk("g2b_0011", {28'd0, out_data}, 32'h2);
        send(1'b0, 4'b0111);
        chk("g2b_0111", {28'd0, out_data}, 32'h5);
        send(1'b0, 4'b0101);
        chk("g2b_0101", {26'd0, out_mode, out_err, out_data}, {26'd0, 1'b0, 1'b0, 4'b0110});
        chk("g2b_err_count", {24'd0, err_count}, 32'd0);
        idle();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Binary-to-Gray
        send(1'b1, 4'b0110);
        chk("b2g_0110", {26'd0, out_mode, out_err, out_data}, {26'd0, 1'b1, 1'b0, 4'b0101});
        send(1'b1, 4'b1111);
        chk("b2g_1111", {26'd0, out_mode, out_err, out_data}, {26'd0, 1'b1, 1'b0, 4'b1000});
        send(1'b1, 4'b1000);
        chk("b2g_1000", {26'd0, out_mode, out_err, out_data}, {26'd0, 1'b1, 1'b0, 4'b1100});

        // Backpressure: held word stays stable, next word waits for out_ready
        pulse_reset();
        send(1'b0, 4'b0011);
        chk("bp_first", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'b0010});
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = 4'b0010;
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {26'd0, in_ready, out_valid, out_data}, {26'd0, 1'b0, 1'b1, 4'b0010});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        send(1'b0, 4'b0010);
        chk("bp_second", {26'd0, out_valid, out_err, out_data}, {26'd0, 1'b1, 1'b0, 4'b0011});

        // Adjacency checks, mode-1 word does not touch history, wrap-around legal
        pulse_reset();
        send(1'b0, 4'b0000);
        chk("adj_first", {31'd0, out_err}, 32'd0);
        send(1'b0, 4'b0011);
        chk("adj_viol", {27'd0, out_err, out_data}, {27'd0, 1'b1, 4'b0010});
        chk("adj_viol_count", {24'd0, err_count}, 32'd1);
        send(1'b0, 4'b0011);
        chk("adj_repeat", {31'd0, out_err}, 32'd0);
        send(1'b1, 4'b1111);
        chk("adj_mode1", {27'd0, out_err, out_data}, {27'd0, 1'b0, 4'b1000});
        send(1'b0, 4'b0010);
        chk("adj_after_mode1", {27'd0, out_err, out_data}, {27'd0, 1'b0, 4'b0011});
        send(1'b0, 4'b0000);
        send(1'b0, 4'b1000);
        chk("adj_1000", {27'd0, out_err, out_data}, {27'd0, 1'b0, 4'b1111});
        send(1'b0, 4'b0000);
        chk("adj_wrap", {27'd0, out_err, out_data}, {27'd0, 1'b0, 4'b0000});
        chk("adj_count_final", {24'd0, err_count}, 32'd1);
        clr_err = 1'b1;
        idle();
        clr_err = 1'b0;
        chk("clr_idle", {24'd0, err_count}, 32'd0);

        // Saturation on the CNT_W=2 instance, clear beats a same-cycle increment
        pulse_reset();
        send(1'b0, 4'b0000);
        send(1'b0, 4'b0011);
        chk("sat_1", {30'd0, err_count2}, 32'd1);
        send(1'b0, 4'b0000);
        chk("sat_2", {30'd0, err_count2}, 32'd2);
        send(1'b0, 4'b0011);
        chk("sat_3", {30'd0, err_count2}, 32'd3);
        send(1'b0, 4'b0000);
        chk("sat_4", {30'd0, err_count2}, 32'd3);
        send(1'b0, 4'b0011);
        chk("sat_5", {30'd0, err_count2}, 32'd3);
        chk("sat_wide_5", {24'd0, err_count}, 32'd5);
        clr_err = 1'b1;
        send(1'b0, 4'b0000);
        clr_err = 1'b0;
        chk("sat_clr", {30'd0, err_count2}, 32'd0);
        chk("sat_clr_err_flag", {31'd0, out_err2}, 32'd1);
        chk("sat_wide_clr", {24'd0, err_count}, 32'd0);

        // Asynchronous reset while a word is held under backpressure
        pulse_reset();
        send(1'b0, 4'b0000);
        send(1'b0, 4'b0011);
        send(1'b0, 4'b0000);
        out_ready = 1'b0;
        chk("ar_pre_count", {24'd0, err_count}, 32'd2);
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_count", {24'd0, err_count}, 32'd0);
        chk("ar_data", {28'd0, out_data}, 32'd0);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        send(1'b0, 4'b1111);
        chk("ar_first_word", {26'd0, out_valid, out_err, out_data}, {26'd0, 1'b1, 1'b0, 4'b1010});
        chk("ar_count_after", {24'd0, err_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_code_converter_pipe.md
GRAY_CODE_CONVERTER_PIPE -- requirements
Module: gray_code_converter_pipe

Interface
REQ-001: Parameter WIDTH, default 4, code word width in bits (>=2).
REQ-002: Parameter CNT_W, default 8, adjacency-error counter width (>=1).
REQ-003: clk  input  1  single clock; all state on rising edge.
REQ-004: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005: in_valid  input  1  upstream word valid.
REQ-006: in_ready  output  1  block can accept a word this cycle.
REQ-007: in_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray.
REQ-008: in_data  input  WIDTH  code word to convert.
REQ-009: out_valid  output  1  converted word valid.
REQ-010: out_ready  input  1  downstream accepts word.
REQ-011: out_data  output  WIDTH  converted word.
REQ-012: out_mode  output  1  in_mode of the word on out_data.
REQ-013: out_err  output  1  word on out_data violated Gray adjacency.
REQ-014: err_count  output  CNT_W  saturating count of adjacency violations.
REQ-015: clr_err  input  1  synchronous clear of err_count.

Function
REQ-016: Accept occurs in a cycle with in_valid=1 and in_ready=1; transfer out occurs with out_valid=1 and out_ready=1.
REQ-017: in_ready SHALL equal (!out_valid || out_ready), combinationally; single-entry output register, no bubble under continuous flow.
REQ-018: Latency SHALL be exactly one cycle: word accepted at edge N appears on out_data with out_valid=1 after edge N.
REQ-019: While out_valid=1 and out_ready=0, out_data, out_mode, out_err SHALL hold stable.
REQ-020: out_valid SHALL clear after a transfer-out edge with no simultaneous accept; on simultaneous transfer-out and accept, out_valid stays 1 with the new word.
REQ-021: Mode 0: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i] for i=WIDTH-2..0.
REQ-022: Mode 1: g = b XOR (b >> 1), logical shift.
REQ-023: History: registers last_gray (WIDTH) and has_last (1) SHALL update only on mode-0 accepts (last_gray<=in_data, has_last<=1); mode-1 accepts leave them unchanged.
REQ-024: A mode-0 accept with has_last=1 and Hamming distance(in_data, last_gray) > 1 is a violation; distance 0 (repeat) or 1 is legal.
REQ-025: First mode-0 word after reset (has_last=0) SHALL never be a violation; mode-1 words never violate.
REQ-026: out_err SHALL be registered alongside out_data for the same word (1 = violation).
REQ-027: err_count SHALL increment by 1 on each violating accept, saturating at 2^CNT_W-1 (no wrap).
REQ-028: clr_err=1 SHALL set err_count to 0 at next edge; clear wins over a simultaneous increment.
REQ-029: Wrap-around of a WIDTH-bit Gray sequence (e.g. 1000 -> 0000, WIDTH=4) SHALL be legal (distance 1).

Reset
REQ-030: While rst=0, immediately and regardless of clk: out_valid=0, out_data=0, out_mode=0, out_err=0, err_count=0, last_gray=0, has_last=0.
REQ-031: in_ready SHALL read 1 during reset (follows REQ-017 with out_valid=0); accepts are ignored while rst=0.
REQ-032: Reset asserted mid-operation SHALL discard any held output word; no partial transfer.

Verification (WIDTH=4, CNT_W=8 unless stated)
REQ-033: Mode 0, out_ready=1, inputs 0000,0001,0011,0111,0101 back-to-back -> out_data 0000,0001,0010,0101,0110 each one cycle later, out_err=0, err_count=0.
REQ-034: Mode 1, inputs 0110, 1111, 1000 -> out_data 0101, 1000, 1100, out_mode=1, out_err=0.
REQ-035: Backpressure: word 0011 (mode 0) accepted, out_ready=0 for 3 cycles -> in_ready=0, out_data=0010 stable; next word 0010 accepted in cycle out_ready returns to 1, appears next cycle.
REQ-036: Adjacency: mode-0 0000 then 0011 -> second word out_err=1, err_count=1; then 0011 repeat -> out_err=0; interleaved mode-1 word 1111 -> no history change, next mode-0 0010 legal.
REQ-037: CNT_W=2: five violating accepts -> err_count 1,2,3,3,3; clr_err=1 in the cycle of a further violating accept -> err_count=0.
REQ-038: rst=0 asserted asynchronously while out_valid=1, out_ready=0, err_count=2 -> out_valid=0, err_count=0 before next edge; after release, mode-0 word 1111 -> out_err=0.
